mc_control_unit: RTL

- Parametrised multicycle main controller for the MIPS multicycle datapath.
- Sequences fetch/decode/execute/memory/writeback and drives every datapath control strobe: PC enable, address select, memory write, IR write, register-file write, mux selects and ALU control.
- Adds memory wait-states, a start/halt handshake and illegal-instruction trapping.
- Sits beside the datapath wrapper and consumes the opcode, funct and ALU zero flag fed back from the instruction register.

---
 rtl/mc_pkg.sv | 52 +++++
 rtl/mc_alu_decoder.sv | 26 ++
 rtl/mc_control_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the MIPS multicycle controller: FSM states, opcode/funct
// codes and the datapath mux/ALU encodings driven by mc_control_unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE,
    S_ALUWB,
    S_ADDIEX,
    S_ADDIWB,
    S_BRANCH,
    S_JUMP,
    S_BNEQ,
    S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct decoder: maps funct to the ALUControl code and flags unsupported
// functs so the controller can trap them in DECODE.
module mc_alu_decoder
  import mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [5:0]           funct_i,
  output logic [ALUCTRL_W-1:0] alu_ctrl_o,
  output logic                 funct_valid_o
);

  always_comb begin
    alu_ctrl_o    = ALUCTRL_W'(ALU_ADD);
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALUCTRL_W'(ALU_ADD);
      FN_SUB:  alu_ctrl_o = ALUCTRL_W'(ALU_SUB);
      FN_AND:  alu_ctrl_o = ALUCTRL_W'(ALU_AND);
      FN_OR:   alu_ctrl_o = ALUCTRL_W'(ALU_OR);
      FN_SLT:  alu_ctrl_o = ALUCTRL_W'(ALU_SLT);
      default: funct_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS main controller with memory wait-states, start/halt handshake and
// illegal-instruction trapping. Define MC_BNE_EN to add bne support (BNEQ state).
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int MEM_LATENCY = 0,
  parameter int ALUCTRL_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 PCen,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 busy,
  output logic                 illegal
);

  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 illegal_q, illegal_d;
  logic                 lastCycle;
  logic [ALUCTRL_W-1:0] functAlu;
  logic                 functValid;

  mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .funct_i       (funct),
    .alu_ctrl_o    (functAlu),
    .funct_valid_o (functValid)
  );

  assign lastCycle = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // The counter only advances while a memory state is waiting; any exit leaves it at zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    illegal_d  = illegal_q;
    PCen       = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = PCSRC_ALU;
    ALUControl = '0;
    busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    illegal    = illegal_q;

    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALUCTRL_W'(ALU_ADD);
        PCSrc      = PCSRC_ALU;
        IRWrite    = lastCycle;
        PCen       = lastCycle;
        if (lastCycle) state_d = S_DECODE;
        else           cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMMSH;
        ALUControl = ALUCTRL_W'(ALU_ADD);
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (functValid) state_d = S_EXECUTE;
            else begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:  state_d = S_BNEQ;
`else
          OP_BNE: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
`endif
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALUCTRL_W'(ALU_ADD);
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD = 1'b1;
        if (lastCycle) state_d = S_MEMWB;
        else           cnt_d   = cnt_q + CNT_W'(1);
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = lastCycle;
        if (lastCycle) state_d = S_FETCH;
        else           cnt_d   = cnt_q + CNT_W'(1);
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = functAlu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH, S_BNEQ: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALUCTRL_W'(ALU_SUB);
        PCSrc      = PCSRC_ALUOUT;
        PCen       = (state_q == S_BRANCH) ? zero : ~zero;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCen    = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
